vc_arbiter_fsm: RTL and testbench

VC_ARBITER_FSM -- requirements
Module: vc_arbiter_fsm

---
 rtl/vc_arbiter_fsm.sv | 129 ++++++++++++
 tb/tb_vc_arbiter_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter_fsm.sv
// Two-VC to two-D-FIFO arbiter: moves words from VC0/VC1 into D0/D1 (chosen by word MSB)
// with VC0 priority, bounded VC1 starvation, threshold configuration and error lockout.
module vc_arbiter_fsm #(
    parameter int DATA_WIDTH = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [3:0]            umbral_vc_in,
    input  logic [3:0]            umbral_d_in,
    input  logic                  empty_vc0,
    input  logic                  empty_vc1,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  almost_full_d0,
    input  logic                  almost_full_d1,
    input  logic [3:0]            error_in,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [3:0]            umbral_vc_out,
    output logic [3:0]            umbral_d_out,
    output logic                  fifo_init,
    output logic [4:0]            state,
    output logic                  idle,
    output logic                  error_out
);

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);

    state_t                  state_q;
    logic [2:0]              starve_q;
    logic                    inflight_q;
    logic                    inflight_vc1_q;
    logic                    push_d0_q;
    logic                    push_d1_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [3:0]              umbral_vc_q;
    logic [3:0]              umbral_d_q;

    logic                    any_err;
    logic                    stay_active;
    logic                    pop_ok;
    logic                    grant_vc1;
    logic [DATA_WIDTH-1:0]   src_word;

    assign any_err     = |error_in;
    // ACTIVE and not being pulled away this cycle; pops and pushes only happen here.
    assign stay_active = (state_q == ST_ACTIVE) && !any_err && !init;
    assign pop_ok      = stay_active && !almost_full_d0 && !almost_full_d1;
    assign grant_vc1   = !empty_vc1 && (empty_vc0 || (starve_q == STARVE_LIMIT));
    assign pop_vc0     = pop_ok && !empty_vc0 && !grant_vc1;
    assign pop_vc1     = pop_ok && grant_vc1;
    assign src_word    = inflight_vc1_q ? vc1_data : vc0_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RESET;
            starve_q       <= 3'd0;
            inflight_q     <= 1'b0;
            inflight_vc1_q <= 1'b0;
            push_d0_q      <= 1'b0;
            push_d1_q      <= 1'b0;
            data_q         <= '0;
            umbral_vc_q    <= 4'd0;
            umbral_d_q     <= 4'd0;
        end else begin
            if (state_q == ST_RESET) begin
                state_q <= ST_INIT;
            end else if (any_err) begin
                state_q <= ST_ERROR;
            end else if (init) begin
                state_q <= ST_INIT;
            end else begin
                case (state_q)
                    ST_INIT:   state_q <= ST_IDLE;
                    ST_IDLE:   if (!empty_vc0 || !empty_vc1) state_q <= ST_ACTIVE;
                    ST_ACTIVE: if (empty_vc0 && empty_vc1 && !inflight_q) state_q <= ST_IDLE;
                    default:   state_q <= state_q;
                endcase
            end

            if (state_q == ST_INIT) begin
                umbral_vc_q <= umbral_vc_in;
                umbral_d_q  <= umbral_d_in;
            end

            inflight_q     <= pop_vc0 || pop_vc1;
            inflight_vc1_q <= pop_vc1;

            // A word still in flight when leaving ACTIVE is dropped, never pushed.
            push_d0_q <= 1'b0;
            push_d1_q <= 1'b0;
            if (inflight_q && stay_active) begin
                data_q    <= src_word;
                push_d1_q <= src_word[DATA_WIDTH-1];
                push_d0_q <= !src_word[DATA_WIDTH-1];
            end

            if (pop_vc1 || empty_vc1) begin
                starve_q <= 3'd0;
            end else if (pop_vc0 && (starve_q != STARVE_LIMIT)) begin
                starve_q <= starve_q + 3'd1;
            end
        end
    end

    assign push_d0       = push_d0_q;
    assign push_d1       = push_d1_q;
    assign data_out      = data_q;
    assign umbral_vc_out = umbral_vc_q;
    assign umbral_d_out  = umbral_d_q;
    assign state         = state_q;
    assign idle          = (state_q == ST_IDLE);
    assign error_out     = (state_q == ST_ERROR);
    assign fifo_init     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE) || (state_q == ST_ERROR);

endmodule

// File: tb/tb_vc_arbiter_fsm.sv
// Directed bench for vc_arbiter_fsm: a cycle table of inputs and expected outputs,
// followed by hand sequences for starvation rotation and asynchronous reset mid-transfer.
module tb_vc_arbiter_fsm;

    localparam int DW = 6;
    localparam logic [4:0] S_R = 5'b00001;
    localparam logic [4:0] S_I = 5'b00010;
    localparam logic [4:0] S_D = 5'b00100;
    localparam logic [4:0] S_A = 5'b01000;
    localparam logic [4:0] S_E = 5'b10000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          init = 1'b0;
    logic [3:0]    umbral_vc_in = 4'd0;
    logic [3:0]    umbral_d_in = 4'd0;
    logic          empty_vc0 = 1'b1;
    logic          empty_vc1 = 1'b1;
    logic [DW-1:0] vc0_data = '0;
    logic [DW-1:0] vc1_data = '0;
    logic          almost_full_d0 = 1'b0;
    logic          almost_full_d1 = 1'b0;
    logic [3:0]    error_in = 4'd0;
    logic          pop_vc0, pop_vc1, push_d0, push_d1;
    logic [DW-1:0] data_out;
    logic [3:0]    umbral_vc_out, umbral_d_out;
    logic          fifo_init, idle, error_out;
    logic [4:0]    state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vc_arbiter_fsm #(.DATA_WIDTH(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_vc_in(umbral_vc_in), .umbral_d_in(umbral_d_in),
        .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .almost_full_d0(almost_full_d0), .almost_full_d1(almost_full_d1),
        .error_in(error_in),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
        .data_out(data_out), .umbral_vc_out(umbral_vc_out), .umbral_d_out(umbral_d_out),
        .fifo_init(fifo_init), .state(state), .idle(idle), .error_out(error_out)
    );

    typedef struct {
        logic       r;
        logic       i;
        logic [3:0] uvc;
        logic [3:0] ud;
        logic       e0;
        logic       e1;
        logic [5:0] d0;
        logic       af1;
        logic [3:0] err;
        logic [4:0] xs;
        logic [1:0] xpop;
        logic [1:0] xpush;
        logic [5:0] xd;
        logic [3:0] xuvc;
        logic [3:0] xud;
        logic       xfi;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic i, input logic [3:0] uvc, input logic [3:0] ud,
                       input logic e0, input logic e1, input logic [5:0] d0, input logic af1,
                       input logic [3:0] err, input logic [4:0] xs, input logic [1:0] xpop,
                       input logic [1:0] xpush, input logic [5:0] xd, input logic [3:0] xuvc,
                       input logic [3:0] xud, input logic xfi);
        vec_t v;
        v.r = r; v.i = i; v.uvc = uvc; v.ud = ud; v.e0 = e0; v.e1 = e1; v.d0 = d0;
        v.af1 = af1; v.err = err; v.xs = xs; v.xpop = xpop; v.xpush = xpush; v.xd = xd;
        v.xuvc = xuvc; v.xud = xud; v.xfi = xfi;
        vq.push_back(v);
    endtask

    task automatic check_all(input string nm, input int idx, input logic [4:0] xs,
                             input logic [1:0] xpop, input logic [1:0] xpush, input logic [5:0] xd,
                             input logic [3:0] xuvc, input logic [3:0] xud, input logic xfi);
        logic [25:0] act;
        logic [25:0] exp;
        act = {state, pop_vc1, pop_vc0, push_d1, push_d0, data_out,
               umbral_vc_out, umbral_d_out, fifo_init, idle, error_out};
        exp = {xs, xpop, xpush, xd, xuvc, xud, xfi, (xs == S_D), (xs == S_E)};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
        end else begin
            $display("ok   %s[%0d] outputs=%h", nm, idx, act);
        end
    endtask

    task automatic check_val(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
        end else begin
            $display("ok   %s[%0d] value=%h", nm, idx, act);
        end
    endtask

    initial begin
        // r i uvc ud e0 e1 d0 af1 err | state pop push dout uvc ud fifo_init
        add(0,0,3,5,1,1,6'h00,0,4'h0, S_R,2'b00,2'b00,6'h00,0,0,0);
        add(1,1,3,5,1,1,6'h00,0,4'h0, S_R,2'b00,2'b00,6'h00,0,0,0);
        add(1,1,3,5,1,1,6'h00,0,4'h0, S_I,2'b00,2'b00,6'h00,0,0,0);
        add(1,0,3,5,1,1,6'h00,0,4'h0, S_I,2'b00,2'b00,6'h00,3,5,0);
        add(1,0,3,5,1,1,6'h00,0,4'h0, S_D,2'b00,2'b00,6'h00,3,5,1);
        add(1,0,3,5,0,1,6'h00,0,4'h0, S_D,2'b00,2'b00,6'h00,3,5,1);
        add(1,0,3,5,0,1,6'h00,0,4'h0, S_A,2'b01,2'b00,6'h00,3,5,1);
        add(1,0,3,5,0,1,6'h05,0,4'h0, S_A,2'b01,2'b00,6'h00,3,5,1);
        add(1,0,3,5,1,1,6'h25,0,4'h0, S_A,2'b00,2'b01,6'h05,3,5,1);
        add(1,0,3,5,1,1,6'h00,0,4'h0, S_A,2'b00,2'b10,6'h25,3,5,1);
        add(1,0,3,5,1,1,6'h00,0,4'h0, S_D,2'b00,2'b00,6'h25,3,5,1);
        add(1,0,3,5,0,1,6'h00,0,4'h0, S_D,2'b00,2'b00,6'h25,3,5,1);
        add(1,0,3,5,0,1,6'h00,0,4'h0, S_A,2'b01,2'b00,6'h25,3,5,1);
        add(1,0,3,5,0,1,6'h01,1,4'h0, S_A,2'b00,2'b00,6'h25,3,5,1);
        add(1,0,3,5,0,1,6'h00,1,4'h0, S_A,2'b00,2'b01,6'h01,3,5,1);
        add(1,0,3,5,0,1,6'h00,1,4'h0, S_A,2'b00,2'b00,6'h01,3,5,1);
        add(1,0,3,5,0,1,6'h00,0,4'h0, S_A,2'b01,2'b00,6'h01,3,5,1);
        add(1,0,3,5,0,1,6'h22,0,4'h0, S_A,2'b01,2'b00,6'h01,3,5,1);
        add(1,0,3,5,0,1,6'h03,0,4'h0, S_A,2'b01,2'b10,6'h22,3,5,1);
        add(1,0,3,5,0,1,6'h04,0,4'h1, S_A,2'b00,2'b01,6'h03,3,5,1);
        add(1,0,3,5,0,1,6'h00,0,4'h0, S_E,2'b00,2'b00,6'h03,3,5,1);
        add(1,0,3,5,0,1,6'h00,0,4'h0, S_E,2'b00,2'b00,6'h03,3,5,1);
        add(1,1,7,2,1,1,6'h00,0,4'h0, S_E,2'b00,2'b00,6'h03,3,5,1);
        add(1,0,7,2,1,1,6'h00,0,4'h0, S_I,2'b00,2'b00,6'h03,3,5,0);
        add(1,0,7,2,1,1,6'h00,0,4'h0, S_D,2'b00,2'b00,6'h03,7,2,1);
        add(1,1,7,2,1,1,6'h00,0,4'h2, S_D,2'b00,2'b00,6'h03,7,2,1);
        add(1,0,7,2,1,1,6'h00,0,4'h0, S_E,2'b00,2'b00,6'h03,7,2,1);
        add(1,1,7,2,1,1,6'h00,0,4'h0, S_E,2'b00,2'b00,6'h03,7,2,1);
        add(1,0,7,2,1,1,6'h00,0,4'h0, S_I,2'b00,2'b00,6'h03,7,2,0);
        add(1,0,7,2,1,1,6'h00,0,4'h0, S_D,2'b00,2'b00,6'h03,7,2,1);

        foreach (vq[k]) begin
            @(negedge clk);
            reset = vq[k].r; init = vq[k].i;
            umbral_vc_in = vq[k].uvc; umbral_d_in = vq[k].ud;
            empty_vc0 = vq[k].e0; empty_vc1 = vq[k].e1;
            vc0_data = vq[k].d0; almost_full_d1 = vq[k].af1; error_in = vq[k].err;
            #1;
            check_all("vec", k, vq[k].xs, vq[k].xpop, vq[k].xpush, vq[k].xd,
                      vq[k].xuvc, vq[k].xud, vq[k].xfi);
        end

        // Both VCs stay non-empty: grants rotate VC0 x4 then VC1 x1.
        @(negedge clk);
        empty_vc0 = 1'b0; empty_vc1 = 1'b0; vc0_data = '0; vc1_data = '0;
        #1;
        check_val("starve_idle_pops", 0, {6'd0, pop_vc1, pop_vc0}, 8'h00);
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            #1;
            check_val("grant", j, {6'd0, pop_vc1, pop_vc0}, (j % 5 == 4) ? 8'h02 : 8'h01);
        end
        @(negedge clk);
        empty_vc0 = 1'b1; empty_vc1 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_val("starve_back_idle", 0, {3'd0, state}, {3'd0, S_D});
        check_val("starve_dout", 0, {2'd0, data_out}, 8'h00);

        // Asynchronous reset while a push is out and another word is in flight.
        @(negedge clk);
        empty_vc0 = 1'b0; vc0_data = 6'h15;
        @(negedge clk);
        #1;
        check_val("rst_seq_pop", 0, {6'd0, pop_vc1, pop_vc0}, 8'h01);
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("pre_reset_push", 0, {2'd0, data_out}, 8'h15);
        check_val("pre_reset_pushflags", 0, {6'd0, push_d1, push_d0}, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, S_R, 2'b00, 2'b00, 6'h00, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1; empty_vc0 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check_val("post_reset_push", j, {6'd0, push_d1, push_d0}, 8'h00);
            check_val("post_reset_state", j, {3'd0, state},
                      {3'd0, (j == 0) ? S_R : ((j == 1) ? S_I : S_D)});
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
